ice40_ram_fifo_ctrl: RTL

- Initiator/controller for the SB_RAM40_4K write and read ports. It drives WADDR/WDATA/MASK/WE/WCLKE and RADDR/RE/RCLKE, and consumes RDATA.
- Presents the RAM as a single-clock, first-word-fall-through FIFO with valid/ready on both sides.
- Sits between a streaming producer/consumer and one RAM instance configured for 256x16 (READ_MODE=0, WRITE_MODE=0).

---
 rtl/ice40_ram_pkg.sv | 22 ++
 rtl/ice40_ram_fifo_skid.sv | 92 +++++++++
 rtl/ice40_ram_fifo_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/ice40_ram_pkg.sv
// ice40_ram_pkg: shared constants and types for the SB_RAM40_4K FIFO controller.
//   RAM_ADDR_W / RAM_DATA_W : physical RAM port widths (11-bit address, 16-bit data).
//   FIFO_DEPTH              : words held in the RAM in 256x16 mode.
//   RAM_READ_MODE / RAM_WRITE_MODE : mode value 0 selects 256x16 on both ports.
//   skid_occ_e              : occupancy states of the 2-entry output queue.
package ice40_ram_pkg;
   localparam int RAM_ADDR_W = 11;
   localparam int RAM_DATA_W = 16;
   localparam int FIFO_DEPTH = 256;

   localparam logic [1:0] RAM_READ_MODE  = 2'd0;
   localparam logic [1:0] RAM_WRITE_MODE = 2'd0;

   typedef logic [RAM_ADDR_W-1:0] ram_addr_t;
   typedef logic [RAM_DATA_W-1:0] ram_data_t;

   typedef enum logic [1:0] {
      SKID_EMPTY = 2'd0,
      SKID_ONE   = 2'd1,
      SKID_TWO   = 2'd2
   } skid_occ_e;
endpackage

// File: rtl/ice40_ram_fifo_skid.sv
// ice40_ram_fifo_skid: 2-entry output queue (head + spare) behind the RAM read port.
//   clk, rst      : clock, asynchronous active-high reset.
//   cap, cap_data : RAM read data arriving this cycle (rd_pend in the top).
//   out_ready     : consumer takes the head word.
//   out_valid     : head occupied.   out_data : head register.
//   buf_occ       : number of occupied entries (0..2).
// The top's issue rule guarantees a capture never arrives while both
// entries are held and the head is not being popped.
module ice40_ram_fifo_skid
   import ice40_ram_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cap,
   input  logic [DATA_W-1:0] cap_data,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        buf_occ
);

   skid_occ_e         state_r, state_s;
   logic [DATA_W-1:0] head_r, head_s;
   logic [DATA_W-1:0] spare_r, spare_s;
   logic              pop_s;

   assign out_valid = (state_r != SKID_EMPTY);
   assign out_data  = head_r;
   assign buf_occ   = state_r;
   assign pop_s     = out_valid & out_ready;

   // Next occupancy and entry contents from capture/pop combination.
   always_comb begin
      state_s = state_r;
      head_s  = head_r;
      spare_s = spare_r;
      case (state_r)
         SKID_EMPTY: begin
            if (cap) begin
               head_s  = cap_data;
               state_s = SKID_ONE;
            end else begin
               state_s = SKID_EMPTY;
            end
         end
         SKID_ONE: begin
            if (pop_s && cap) begin
               // head leaves and the new word drops straight into it
               head_s = cap_data;
            end else if (pop_s) begin
               state_s = SKID_EMPTY;
            end else if (cap) begin
               spare_s = cap_data;
               state_s = SKID_TWO;
            end else begin
               state_s = SKID_ONE;
            end
         end
         SKID_TWO: begin
            if (pop_s) begin
               head_s = spare_r;
               if (cap) begin
                  spare_s = cap_data;
               end else begin
                  state_s = SKID_ONE;
               end
            end else begin
               state_s = SKID_TWO;
            end
         end
         default: begin
            state_s = SKID_EMPTY;
         end
      endcase
   end

   // Queue state and entry registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= SKID_EMPTY;
         head_r  <= {DATA_W{1'b0}};
         spare_r <= {DATA_W{1'b0}};
      end else begin
         state_r <= state_s;
         head_r  <= head_s;
         spare_r <= spare_s;
      end
   end

endmodule

// File: rtl/ice40_ram_fifo_ctrl.sv
// ice40_ram_fifo_ctrl: drives one SB_RAM40_4K (256x16) as a first-word-fall-through FIFO.
//   CLK, ASYNCRESET        : clock (also the RAM's RCLK/WCLK), async active-high reset.
//   in_valid/in_ready/in_data    : producer side.
//   out_valid/out_ready/out_data : consumer side.
//   count                  : words held (RAM + in-flight read + output queue), max 258.
//   ram_*                  : RAM write port (WADDR/WDATA/MASK/WE/WCLKE) and read port
//                            (RADDR/RE/RCLKE/RDATA; RDATA valid one cycle after RE).
// Optional macro ICE40_FIFO_ALMOST_FLAGS_EN adds registered almost_full/almost_empty.
module ice40_ram_fifo_ctrl
   import ice40_ram_pkg::*;
#(
   parameter int ADDR_W        = 8,
   parameter int DATA_W        = 16
`ifdef ICE40_FIFO_ALMOST_FLAGS_EN
  ,parameter int AFULL_THRESH  = 240,
   parameter int AEMPTY_THRESH = 4
`endif
) (
   input  logic              CLK,
   input  logic              ASYNCRESET,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W:0]   count,
`ifdef ICE40_FIFO_ALMOST_FLAGS_EN
   output logic              almost_full,
   output logic              almost_empty,
`endif
   output ram_addr_t         ram_WADDR,
   output ram_data_t         ram_WDATA,
   output ram_data_t         ram_MASK,
   output logic              ram_WE,
   output logic              ram_WCLKE,
   output ram_addr_t         ram_RADDR,
   output logic              ram_RE,
   output logic              ram_RCLKE,
   input  ram_data_t         ram_RDATA
);

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(FIFO_DEPTH);
   localparam logic [ADDR_W:0] ZERO_C  = {(ADDR_W+1){1'b0}};

   logic [ADDR_W-1:0] wr_ptr_r, rd_ptr_r;
   logic [ADDR_W:0]   mem_cnt_r, mem_cnt_s;
   logic [ADDR_W:0]   count_r, count_s;
   logic              rd_pend_r;
   logic              push_s, pop_s, issue_s;
   logic [1:0]        buf_occ_s;
   logic [2:0]        inflight_s;

   // Constant RAM ties and address/data drive.
   assign ram_MASK  = {RAM_DATA_W{1'b0}};
   assign ram_WCLKE = 1'b1;
   assign ram_RCLKE = 1'b1;
   assign ram_WADDR = {{(RAM_ADDR_W-ADDR_W){1'b0}}, wr_ptr_r};
   assign ram_RADDR = {{(RAM_ADDR_W-ADDR_W){1'b0}}, rd_ptr_r};
   assign ram_WDATA = in_data;
   assign ram_WE    = push_s;
   assign ram_RE    = issue_s;

   // Space is judged on the committed RAM word count only.
   assign in_ready  = (mem_cnt_r != DEPTH_C);
   assign push_s    = in_valid & in_ready;
   assign pop_s     = out_valid & out_ready;
   assign count     = count_r;

   // A read may start only if its data will find a free queue slot when it lands.
   assign inflight_s = {1'b0, buf_occ_s} + {2'b00, rd_pend_r};
   assign issue_s    = (mem_cnt_r != ZERO_C) && (inflight_s < (3'd2 + {2'b00, pop_s}));

   // Next RAM word count and next total word count.
   always_comb begin
      mem_cnt_s = mem_cnt_r + {{ADDR_W{1'b0}}, push_s} - {{ADDR_W{1'b0}}, issue_s};
      count_s   = mem_cnt_s
                + {{ADDR_W{1'b0}}, issue_s}
                + {{(ADDR_W-1){1'b0}}, buf_occ_s}
                + {{ADDR_W{1'b0}}, rd_pend_r}
                - {{ADDR_W{1'b0}}, pop_s};
   end

   // Pointers, counters and read-pending flag.
   always_ff @(posedge CLK or posedge ASYNCRESET) begin
      if (ASYNCRESET) begin
         wr_ptr_r  <= {ADDR_W{1'b0}};
         rd_ptr_r  <= {ADDR_W{1'b0}};
         mem_cnt_r <= ZERO_C;
         count_r   <= ZERO_C;
         rd_pend_r <= 1'b0;
      end else begin
         wr_ptr_r  <= wr_ptr_r + {{(ADDR_W-1){1'b0}}, push_s};
         rd_ptr_r  <= rd_ptr_r + {{(ADDR_W-1){1'b0}}, issue_s};
         mem_cnt_r <= mem_cnt_s;
         count_r   <= count_s;
         rd_pend_r <= issue_s;
      end
   end

   ice40_ram_fifo_skid #(
      .DATA_W    (DATA_W)
   ) u_skid (
      .clk       (CLK),
      .rst       (ASYNCRESET),
      .cap       (rd_pend_r),
      .cap_data  (ram_RDATA),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .buf_occ   (buf_occ_s)
   );

`ifdef ICE40_FIFO_ALMOST_FLAGS_EN
   localparam logic [ADDR_W:0] AFULL_C  = (ADDR_W+1)'(AFULL_THRESH);
   localparam logic [ADDR_W:0] AEMPTY_C = (ADDR_W+1)'(AEMPTY_THRESH);

   // Threshold flags track the same next-count value as count.
   always_ff @(posedge CLK or posedge ASYNCRESET) begin
      if (ASYNCRESET) begin
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
      end else begin
         almost_full  <= (count_s >= AFULL_C);
         almost_empty <= (count_s <= AEMPTY_C);
      end
   end
`endif

endmodule
